// File: rtl/ts_feature_scanner_if.sv
// Bundles the scan-request handshake, the time-surface read port and the feature-vector outputs
// of the feature scanner into one connection.
interface ts_feature_scanner_if #(
    parameter int ADDR_BITS  = 8,
    parameter int VALUE_BITS = 8
);
    logic                  start;
    logic                  busy;
    logic                  read_enable;
    logic [ADDR_BITS-1:0]  read_addr;
    logic [VALUE_BITS-1:0] read_value;
    logic                  feat_valid;
    logic                  feat_ready;
    logic [15:0]           sum_total;
    logic [19:0]           sum_x;
    logic [19:0]           sum_y;
    logic [13:0]           quad_sum [4];
    logic [8:0]            active_count;

    modport master (
        input  start, read_value, feat_ready,
        output busy, read_enable, read_addr, feat_valid,
               sum_total, sum_x, sum_y, quad_sum, active_count
    );

    modport slave (
        output start, read_value, feat_ready,
        input  busy, read_enable, read_addr, feat_valid,
               sum_total, sum_x, sum_y, quad_sum, active_count
    );
endinterface

// File: rtl/ts_feature_scanner.sv
// Sweeps every cell of the decayed time surface once per start request and reduces it to a
// feature vector: total, x/y moments, quadrant sums and a count of active cells.
module ts_feature_scanner #(
    parameter int GRID_SIZE     = 16,
    parameter int ADDR_BITS     = 8,
    parameter int VALUE_BITS    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int ACTIVE_THRESH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ts_feature_scanner_if.master bus
);
    localparam int COORD_BITS = ADDR_BITS / 2;
    localparam int CNT_BITS   = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR  = ADDR_BITS'(GRID_SIZE * GRID_SIZE - 1);
    localparam logic [CNT_BITS-1:0]   DRAIN_LAST = CNT_BITS'(READ_LATENCY - 1);
    localparam logic [VALUE_BITS-1:0] THRESH     = VALUE_BITS'(ACTIVE_THRESH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [CNT_BITS-1:0]   drainCnt_q, drainCnt_d;
    logic                  clearAcc;

    logic [READ_LATENCY-1:0] pipeValid_q;
    logic [ADDR_BITS-1:0]    pipeAddr_q [READ_LATENCY];

    logic [15:0] sumTotal_q;
    logic [19:0] sumX_q;
    logic [19:0] sumY_q;
    logic [13:0] quad_q [4];
    logic [8:0]  activeCnt_q;

    logic [ADDR_BITS-1:0]  accAddr;
    logic [COORD_BITS-1:0] accX;
    logic [COORD_BITS-1:0] accY;
    logic [1:0]            accQuad;
    logic [19:0]           xProd;
    logic [19:0]           yProd;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drainCnt_d = drainCnt_q;
        clearAcc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SCAN;
                    addr_d   = '0;
                    clearAcc = 1'b1;
                end
            end
            SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d    = DRAIN;
                    drainCnt_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
            end
            DRAIN: begin
                if (drainCnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + CNT_BITS'(1);
                end
            end
            DONE: begin
                if (bus.feat_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The address travels alongside the memory read so each returning value knows its cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            drainCnt_q  <= '0;
            pipeValid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipeAddr_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            drainCnt_q     <= drainCnt_d;
            pipeValid_q[0] <= (state_q == SCAN);
            pipeAddr_q[0]  <= addr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeAddr_q[i]  <= pipeAddr_q[i-1];
            end
        end
    end

    always_comb begin
        accAddr = pipeAddr_q[READ_LATENCY-1];
        accX    = accAddr[COORD_BITS-1:0];
        accY    = accAddr[ADDR_BITS-1:COORD_BITS];
        accQuad = {accY[COORD_BITS-1], accX[COORD_BITS-1]};
        xProd   = 20'(accX) * 20'(bus.read_value);
        yProd   = 20'(accY) * 20'(bus.read_value);
    end

    always_ff @(posedge clk) begin
        if (rst || clearAcc) begin
            sumTotal_q  <= '0;
            sumX_q      <= '0;
            sumY_q      <= '0;
            activeCnt_q <= '0;
            for (int i = 0; i < 4; i++) quad_q[i] <= '0;
        end else if (pipeValid_q[READ_LATENCY-1]) begin
            sumTotal_q      <= sumTotal_q + 16'(bus.read_value);
            sumX_q          <= sumX_q + xProd;
            sumY_q          <= sumY_q + yProd;
            quad_q[accQuad] <= quad_q[accQuad] + 14'(bus.read_value);
            activeCnt_q     <= activeCnt_q + 9'(bus.read_value >= THRESH);
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.read_enable  = (state_q == SCAN) || (state_q == DRAIN);
    assign bus.read_addr    = addr_q;
    assign bus.feat_valid   = (state_q == DONE);
    assign bus.sum_total    = sumTotal_q;
    assign bus.sum_x        = sumX_q;
    assign bus.sum_y        = sumY_q;
    assign bus.quad_sum[0]  = quad_q[0];
    assign bus.quad_sum[1]  = quad_q[1];
    assign bus.quad_sum[2]  = quad_q[2];
    assign bus.quad_sum[3]  = quad_q[3];
    assign bus.active_count = activeCnt_q;
endmodule
